alu_exec: RTL and testbench

Multi-cycle execute stage that drives the 8-bit `ALU` block from the instruction side. It accepts one decoded operation per handshake and reads operands from a private 4×8 register file or an immediate. It presents the operands and opcode to the ALU, checks the result for errors, and returns the result over a valid/ready interface. On successful response handshake it writes the result back to the register file.

---
 rtl/pisa_pkg.sv | 31 +++
 rtl/alu_exec_if.sv | 29 ++
 rtl/ALU.sv | 44 ++++
 rtl/alu_exec.sv | 112 +++++++++++
 tb/tb_alu_exec.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pisa_pkg.sv
// Shared opcode map, operation legality and execute-stage state encoding
// for the 8-bit PISA datapath.
package pisa_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_MOD = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
         OP_XOR, OP_SHL, OP_SHR, OP_SRA, OP_MOD: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Instruction-side request and result return channels of the execute stage.
interface alu_exec_if;

   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [1:0] in_rd;
   logic [1:0] in_ra;
   logic [1:0] in_rb;
   logic [7:0] in_imm;
   logic       in_use_imm;

   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_zero;
   logic       res_err;

   modport master (
      output in_valid, in_op, in_rd, in_ra, in_rb, in_imm, in_use_imm, res_ready,
      input  in_ready, res_valid, res_data, res_zero, res_err
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_ra, in_rb, in_imm, in_use_imm, res_ready,
      output in_ready, res_valid, res_data, res_zero, res_err
   );

endinterface

// File: rtl/ALU.sv
// Combinational 8-bit unsigned ALU. Faulting operations (illegal opcode,
// divide/modulo by zero) return zero data with err set.
module ALU
   import pisa_pkg::*;
(
   input  logic [3:0] op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y,
   output logic       zero,
   output logic       err
);

   logic       shift_out;
   logic       div_zero;
   logic [7:0] y_raw;

   assign shift_out = (b >= 8'd8);
   assign div_zero  = ((op == OP_DIV) || (op == OP_MOD)) && (b == 8'd0);
   assign err       = !op_legal(op) || div_zero;

   always_comb begin
      y_raw = 8'd0;
      case (op)
         OP_ADD: y_raw = a + b;
         OP_SUB: y_raw = a - b;
         OP_MUL: y_raw = a * b;
         OP_DIV: y_raw = div_zero ? 8'd0 : a / b;
         OP_MOD: y_raw = div_zero ? 8'd0 : a % b;
         OP_AND: y_raw = a & b;
         OP_OR:  y_raw = a | b;
         OP_XOR: y_raw = a ^ b;
         OP_SHL: y_raw = shift_out ? 8'd0 : (a << b[2:0]);
         // operands are unsigned, so arithmetic right shift is a logical one
         OP_SHR,
         OP_SRA: y_raw = shift_out ? 8'd0 : (a >> b[2:0]);
         default: y_raw = 8'd0;
      endcase
   end

   assign y    = err ? 8'd0 : y_raw;
   assign zero = (y == 8'd0);

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute stage: accept, run the ALU for one cycle, hold the
// result until consumed, then write it back to the private register file.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | in_ready=1; operands fetched from rf/imm on accept
//   ST_EXEC | ALU driven from latched operands; result captured at edge
//   ST_RESP | res_valid=1; result held; write-back on res_ready
module alu_exec
   import pisa_pkg::*;
#(
   parameter int NREGS = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_exec_if.slave       bus,
   input  logic [1:0]      dbg_sel,
   output logic [7:0]      dbg_data
);

   state_t     state_q, state_d;

   logic [3:0] op_q;
   logic [1:0] rd_q;
   logic [7:0] a_q, b_q;
   logic [7:0] res_data_q;
   logic       res_zero_q, res_err_q;
   logic [7:0] rf [NREGS];

   logic       accept, capture, retire;
   logic [7:0] opnd_a, opnd_b;
   logic [7:0] alu_y;
   logic       alu_zero, alu_err;

   ALU u_alu (
      .op   (op_q),
      .a    (a_q),
      .b    (b_q),
      .y    (alu_y),
      .zero (alu_zero),
      .err  (alu_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      retire  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            capture = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.res_ready) begin
               retire  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign opnd_a = rf[bus.in_ra];
   assign opnd_b = bus.in_use_imm ? bus.in_imm : rf[bus.in_rb];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q       <= 4'd0;
         rd_q       <= 2'd0;
         a_q        <= 8'd0;
         b_q        <= 8'd0;
         res_data_q <= 8'd0;
         res_zero_q <= 1'b0;
         res_err_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++) rf[i] <= 8'd0;
      end else begin
         if (accept) begin
            op_q <= bus.in_op;
            rd_q <= bus.in_rd;
            a_q  <= opnd_a;
            b_q  <= opnd_b;
         end
         if (capture) begin
            res_data_q <= alu_y;
            res_zero_q <= alu_zero;
            res_err_q  <= alu_err;
         end
         // faulted results are reported but never committed
         if (retire && !res_err_q) rf[rd_q] <= res_data_q;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.res_valid = (state_q == ST_RESP);
   assign bus.res_data  = res_data_q;
   assign bus.res_zero  = res_zero_q;
   assign bus.res_err   = res_err_q;
   assign dbg_data      = rf[dbg_sel];

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed operations with literal expectations and a
// cycle-level reference model of the register file and result channel.
module tb_alu_exec;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_sel;
   logic [7:0] dbg_data;

   alu_exec_if bus ();

   alu_exec #(.NREGS(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // reference arithmetic: returns {err, data}
   function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
      int r;
      r = 0;
      case (op)
         0:  r = (a + b) % 256;
         1:  r = (a - b + 256) % 256;
         2:  r = (a * b) % 256;
         3:  begin if (b == 0) return 9'h100; r = a / b; end
         4:  r = a & b;
         6:  r = a | b;
         7:  r = a ^ b;
         8:  r = (b >= 8) ? 0 : (a * (2 ** b)) % 256;
         9, 10: r = (b >= 8) ? 0 : a / (2 ** b);
         12: begin if (b == 0) return 9'h100; r = a % b; end
         default: return 9'h100;
      endcase
      return {1'b0, r[7:0]};
   endfunction

   // reference model state, advanced once per cycle at the falling edge
   logic [7:0] m_rf [4];
   bit         model_ok = 0;
   bit         m_busy   = 0;
   int         m_age    = 0;
   logic [7:0] m_d;
   logic       m_e;
   logic [1:0] m_rd;

   always @(negedge clk) begin
      logic [8:0] r;
      int a, b;
      if (model_ok) begin
         check("in_ready", {31'd0, bus.in_ready}, {31'd0, !m_busy});
         check("res_valid", {31'd0, bus.res_valid}, {31'd0, (m_busy && m_age == 2)});
         if (m_busy && m_age == 2) begin
            check("res_data", {24'd0, bus.res_data}, {24'd0, m_d});
            check("res_zero", {31'd0, bus.res_zero}, {31'd0, (m_d == 8'd0)});
            check("res_err", {31'd0, bus.res_err}, {31'd0, m_e});
         end
         check("dbg_data", {24'd0, dbg_data}, {24'd0, m_rf[dbg_sel]});
      end
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
         m_busy   = 0;
         model_ok = 1;
      end else if (model_ok) begin
         if (!m_busy) begin
            if (bus.in_valid) begin
               a = int'(m_rf[bus.in_ra]);
               b = bus.in_use_imm ? int'(bus.in_imm) : int'(m_rf[bus.in_rb]);
               r = ref_alu(int'(bus.in_op), a, b);
               m_e    = r[8];
               m_d    = r[7:0];
               m_rd   = bus.in_rd;
               m_busy = 1;
               m_age  = 1;
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else if (bus.res_ready) begin
            if (!m_e) m_rf[m_rd] = m_d;
            m_busy = 0;
         end
      end
   end

   initial begin
      dbg_sel = 2'd0;
      forever begin
         @(posedge clk);
         #3 dbg_sel = dbg_sel + 2'd1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic run_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] imm, input logic ui,
                         input int hold, output logic [7:0] d, output logic z,
                         output logic e, output int lat);
      int n;
      n = 0;
      while (!bus.in_ready && n < 20) begin @(posedge clk); #2; n++; end
      bus.in_op      = op;
      bus.in_rd      = rd;
      bus.in_ra      = ra;
      bus.in_rb      = rb;
      bus.in_imm     = imm;
      bus.in_use_imm = ui;
      bus.in_valid   = 1'b1;
      bus.res_ready  = (hold == 0);
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
      lat = 1;
      n   = 0;
      while (!bus.res_valid && n < 10) begin @(posedge clk); #2; lat++; n++; end
      d = bus.res_data;
      z = bus.res_zero;
      e = bus.res_err;
      if (hold > 0) begin
         bus.in_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            check("hold_valid", {31'd0, bus.res_valid}, 32'd1);
            check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
         end
         bus.in_valid  = 1'b0;
         bus.res_ready = 1'b1;
         @(posedge clk); #2;
         check("release_idle", {31'd0, bus.in_ready}, 32'd1);
         check("release_valid", {31'd0, bus.res_valid}, 32'd0);
      end else begin
         @(posedge clk); #2;
      end
   endtask

   task automatic op_chk(input string name, input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                         input logic ui, input int hold, input logic [7:0] exp_d,
                         input logic exp_e);
      logic [7:0] d;
      logic       z, e;
      int         lat;
      run_op(op, rd, ra, rb, imm, ui, hold, d, z, e, lat);
      check({name, "_data"}, {24'd0, d}, {24'd0, exp_d});
      check({name, "_zero"}, {31'd0, z}, {31'd0, (exp_d == 8'd0)});
      check({name, "_err"}, {31'd0, e}, {31'd0, exp_e});
      check({name, "_latency"}, lat, 32'd2);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_op      = 4'd0;
      bus.in_rd      = 2'd0;
      bus.in_ra      = 2'd0;
      bus.in_rb      = 2'd0;
      bus.in_imm     = 8'd0;
      bus.in_use_imm = 1'b0;
      bus.res_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      check("rst_res_data", {24'd0, bus.res_data}, 32'd0);
      check("rst_res_zero", {31'd0, bus.res_zero}, 32'd0);
      check("rst_res_err", {31'd0, bus.res_err}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      op_chk("add_r0",  4'b0000, 2'd0, 2'd0, 2'd0, 8'h05, 1'b1, 0, 8'h05, 1'b0);
      op_chk("add_r1",  4'b0000, 2'd1, 2'd0, 2'd0, 8'hFE, 1'b1, 0, 8'h03, 1'b0);
      check("model_r1", {24'd0, m_rf[1]}, 32'h03);
      op_chk("add_r2",  4'b0000, 2'd2, 2'd3, 2'd0, 8'h10, 1'b1, 0, 8'h10, 1'b0);
      op_chk("mul",     4'b0010, 2'd2, 2'd2, 2'd0, 8'h11, 1'b1, 0, 8'h10, 1'b0);
      op_chk("shl9",    4'b1000, 2'd0, 2'd2, 2'd0, 8'h09, 1'b1, 0, 8'h00, 1'b0);
      check("model_shl_wb", {24'd0, m_rf[0]}, 32'h00);
      op_chk("div0",    4'b0011, 2'd1, 2'd2, 2'd3, 8'h00, 1'b0, 0, 8'h00, 1'b1);
      op_chk("op_f",    4'b1111, 2'd1, 2'd2, 2'd0, 8'h01, 1'b1, 0, 8'h00, 1'b1);
      check("model_err_nowb", {24'd0, m_rf[1]}, 32'h03);
      op_chk("or_bp",   4'b0110, 2'd3, 2'd2, 2'd1, 8'h00, 1'b0, 5, 8'h13, 1'b0);
      check("model_r3", {24'd0, m_rf[3]}, 32'h13);
      op_chk("sub_rdra", 4'b0001, 2'd1, 2'd1, 2'd0, 8'h04, 1'b1, 0, 8'hFF, 1'b0);
      check("model_r1_ff", {24'd0, m_rf[1]}, 32'hFF);
      op_chk("raw_next", 4'b0000, 2'd0, 2'd1, 2'd0, 8'h00, 1'b1, 0, 8'hFF, 1'b0);
      op_chk("sra",     4'b1010, 2'd2, 2'd1, 2'd0, 8'h04, 1'b1, 0, 8'h0F, 1'b0);
      op_chk("shr8",    4'b1001, 2'd2, 2'd1, 2'd0, 8'h08, 1'b1, 0, 8'h00, 1'b0);
      op_chk("div",     4'b0011, 2'd2, 2'd1, 2'd0, 8'h10, 1'b1, 0, 8'h0F, 1'b0);
      op_chk("mod",     4'b1100, 2'd2, 2'd1, 2'd0, 8'h10, 1'b1, 0, 8'h0F, 1'b0);
      op_chk("and",     4'b0100, 2'd2, 2'd1, 2'd0, 8'h3C, 1'b1, 0, 8'h3C, 1'b0);
      op_chk("xor",     4'b0111, 2'd2, 2'd1, 2'd0, 8'h0F, 1'b1, 0, 8'hF0, 1'b0);
      op_chk("op_5",    4'b0101, 2'd2, 2'd1, 2'd0, 8'h01, 1'b1, 0, 8'h00, 1'b1);
      check("model_r2_keep", {24'd0, m_rf[2]}, 32'hF0);
      op_chk("shl1",    4'b1000, 2'd2, 2'd3, 2'd0, 8'h01, 1'b1, 0, 8'h26, 1'b0);
      op_chk("mod0",    4'b1100, 2'd2, 2'd1, 2'd0, 8'h00, 1'b1, 0, 8'h00, 1'b1);

      // reset while the operation sits in EXEC
      bus.in_op      = 4'b0000;
      bus.in_rd      = 2'd3;
      bus.in_ra      = 2'd1;
      bus.in_imm     = 8'h01;
      bus.in_use_imm = 1'b1;
      bus.in_valid   = 1'b1;
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
      check("exec_in_ready", {31'd0, bus.in_ready}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #2;
      check("rst_exec_valid", {31'd0, bus.res_valid}, 32'd0);
      check("rst_exec_ready", {31'd0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) check("model_rf_clear", {24'd0, m_rf[i]}, 32'd0);
      @(posedge clk); #2;
      check("post_rst_valid", {31'd0, bus.res_valid}, 32'd0);
      op_chk("post_rst", 4'b0000, 2'd0, 2'd0, 2'd0, 8'h07, 1'b1, 0, 8'h07, 1'b0);
      repeat (4) @(posedge clk);
      #2;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
